// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch controller.
package fetch_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int CNT_W_DEF    = 16;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load a redirect target, step by one with wrap, or hold.
module fetch_pc_reg #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // A redirect takes priority over sequential stepping; the add wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, drives instruction memory and buffers one
// fetched instruction toward decode behind a valid/ready handshake.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic              buf_free;
  logic              handshake;
  logic              do_branch;
  logic              do_load;

  // Halt blocks new loads but a branch in the same cycle still redirects.
  always_comb begin
    buf_free   = !instr_valid || instr_ready;
    handshake  = instr_valid && instr_ready;
    do_branch  = (state == RUN) && br_valid;
    do_load    = (state == RUN) && !br_valid && !halt_req && buf_free;
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (halt_req) state_next = HALTED;
      HALTED:  if (start)    state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign imem_addr = pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (do_branch),
    .inc    (do_load),
    .target (br_target),
    .pc     (pc)
  );

  // Branch flush beats the handshake drain; an unaccepted instruction is never dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      running     <= 1'b0;
      halted      <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      halted  <= (state_next == HALTED);
      if (do_branch) begin
        instr_valid <= 1'b0;
      end else if (do_load) begin
        instr       <= imem_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (handshake) begin
        instr_valid <= 1'b0;
      end
      if (handshake && (fetch_count != {CNT_W{1'b1}})) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the 8-bit instruction memory for the processor core. It owns the program counter, drives the memory address, and registers each fetched instruction into a one-entry output buffer. The buffer feeds decode through a valid/ready handshake. It also handles branch redirects, start/halt control and an accepted-instruction counter, and sits between the instruction memory and the decode stage.

## Interface
Parameters:
- `ADDR_W`, 8, PC / memory address width
- `DATA_W`, 8, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `CNT_W`, 16, width of accepted-instruction counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; **synchronous, active-high**
- `start`  in  1  begin or resume fetching (IDLE/HALTED → RUN)
- `halt_req`  in  1  stop fetching after the current cycle
- `br_valid`  in  1  redirect request, honoured in RUN only
- `br_target`  in  ADDR_W  redirect address
- `imem_addr`  out  ADDR_W  address to instruction memory, always equals PC
- `imem_data`  in  DATA_W  memory read data, combinational from `imem_addr`
- `instr`  out  DATA_W  buffered instruction
- `instr_pc`  out  ADDR_W  address `instr` was fetched from
- `instr_valid`  out  1  buffer holds an instruction
- `instr_ready`  in  1  decode accepts the instruction this cycle
- `running`  out  1  state == RUN
- `halted`  out  1  state == HALTED
- `fetch_count`  out  CNT_W  accepted instructions (`instr_valid && instr_ready`), saturating

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALTED.
- Reset values:
  - state = IDLE, PC = `RESET_PC`.
  - `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `fetch_count` = 0.
  - `running` = 0, `halted` = 0.
- Transitions:
  - IDLE —`start`→ RUN.
  - RUN —`halt_req`→ HALTED.
  - HALTED —`start`→ RUN.
  - `start` and `halt_req` together: `halt_req` wins in RUN, `start` wins in IDLE/HALTED.
- Buffer "free" = `!instr_valid || instr_ready`.
- RUN, no branch, buffer free, `halt_req` = 0:
  - `instr` ← `imem_data`, `instr_pc` ← PC, `instr_valid` ← 1.
  - PC ← PC+1, modulo 2^ADDR_W (255 → 0 wraps silently).
- RUN, no branch, buffer not free: hold everything; PC unchanged.
- RUN, `br_valid`:
  - PC ← `br_target`, `instr_valid` ← 0 (flush); no load this cycle.
  - A simultaneous handshake still counts in `fetch_count`.
- RUN, `halt_req` without branch: no new load.
  - A buffered instruction stays valid until accepted; it is never dropped.
  - If it is accepted this cycle, `instr_valid` ← 0.
- `br_valid` and `halt_req` together: branch applied (PC ← target, flush), then HALTED.
- IDLE/HALTED:
  - No loads; `br_valid` ignored.
  - The handshake still drains the buffer and counts.
- `fetch_count` increments on every handshake in any state and saturates at all-ones.
- `rst` mid-operation returns every output to its reset value on the next edge, regardless of state or handshake.

## Timing
- All outputs are registered except `imem_addr`, which is driven directly from the PC register.
- `start` asserted in cycle N → RUN at N+1 → first load at the N+1 edge → `instr_valid` = 1 at N+2 with `instr_pc` = `RESET_PC`.
- Steady state with `instr_ready` held high: one instruction per cycle and consecutive `instr_pc` values.
- `br_valid` in cycle N:
  - `instr_valid` = 0 at N+1.
  - Target instruction is valid at N+2.
  - One bubble.
- `halt_req` in cycle N: no instruction with `instr_pc` ≥ the PC at cycle N is loaded after N.
- Backpressure: while `instr_valid && !instr_ready`, `instr` and `instr_pc` are stable.

## Structure
- Shared package `fetch_pkg`:
  - State enum (IDLE, RUN, HALTED).
  - Default `ADDR_W`/`DATA_W`/`CNT_W` constants.
  - `RESET_PC` default.
- One sub-module `fetch_pc_reg`:
  - Holds PC.
  - Controls: load-target, increment-with-wrap, hold, reset to `RESET_PC`.
- FSM, output buffer and counter stay in the top.

## Test plan
- Reset, `start` at cycle 2, `instr_ready` = 1 against a memory holding 0xB0, 0xB5, 0xBA → `instr_valid` rises at cycle 4; `instr` = 0xB0, 0xB5, 0xBA with `instr_pc` = 0, 1, 2; `fetch_count` = 3.
- `instr_ready` low for 4 cycles while valid at PC 5 → `instr`/`instr_pc` = PC 5 held, PC stays 6, no count; release → PC 6 loads next cycle.
- `br_valid` with `br_target` = 0x20 while the buffer holds PC 7 and is accepted the same cycle → count +1; next cycle `instr_valid` = 0; following cycle `instr_pc` = 0x20.
- `halt_req` with a buffered instruction and `instr_ready` = 0 → HALTED, instruction retained; accept later → count +1, no further loads; `start` → fetching resumes at the held PC.
- PC at 255 in steady fetch → next `instr_pc` = 0. Separately, `br_valid` + `halt_req` together → PC = target, HALTED.
- Assert `rst` while RUN with valid data → next cycle all outputs at their reset values and state IDLE; `br_valid` in IDLE has no effect.
